ft232h_sync_fifo_tx: RTL and testbench
======================================

Name: ft232h_sync_fifo_tx

Overview:
FPGA-side transmit controller for the FT232H in 245 synchronous FIFO mode. It takes bytes from an internal AXI-Stream source and drives the FT232H write-side pins (data, wr_n) according to txe_n. It requests a send-immediate (siwu_n) after the link has been idle for a set time. It sits directly upstream of ft232h_bfm in simulation and of the physical FT232H in hardware.

Parameters:
FLUSH_TIMEOUT, 64, idle cycles after the last accepted byte before siwu_n pulses; 0 disables flushing.
COUNT_WIDTH, 16, width of the bytes_sent status counter.

Ports:
clk  input  1  FT232H 60 MHz CLKOUT; the only clock.
reset  input  1  synchronous, active-high reset.
s_tdata  input  8  byte from the upstream stream.
s_tvalid  input  1  upstream byte valid.
s_tready  output  1  controller can take a byte (registered).
txe_n  input  1  FT232H TX FIFO has space (active low).
wr_n  output  1  write strobe to FT232H (registered, active low).
data  output  8  byte to FT232H (registered).
rd_n  output  1  tied high (no RX path).
oe_n  output  1  tied high (FPGA always drives data).
siwu_n  output  1  send-immediate strobe (registered, active low).
bytes_sent  output  COUNT_WIDTH  count of bytes consumed by the FT232H; wraps.

Behaviour:
- Reset values: wr_n=1, data=0, siwu_n=1, s_tready=0, bytes_sent=0. rd_n and oe_n are always 1. All buffers are emptied and the flush state is cleared.
- s_tready rises on the first edge after reset deasserts.
- Reset mid-operation discards buffered bytes. wr_n is 1 after the next edge.
- FT transfer rule: a byte is consumed at an edge where registered wr_n==0 and txe_n==0. Signal ft_acc = ~wr_n & ~txe_n.
- Buffering uses two entries: an output register (OUT, drives data; wr_n = ~OUT.valid) and a skid register (SKID).
- s_tready is registered as ~SKID.valid of the next state. An input handshake is s_tvalid & s_tready.
- Each edge:
  - If OUT is empty or ft_acc, OUT loads SKID if SKID is valid, else the input byte if an input handshake occurs, else OUT becomes empty.
  - Otherwise an input handshake loads SKID.
  - SKID clears when it is moved into OUT.
- With txe_n high and wr_n low, hold data and wr_n unchanged; the byte retries until consumed. No loss, no duplication.
- Latency: an input handshake at edge k into an empty controller drives wr_n=0 with that byte after edge k. The FT232H consumes it at edge k+1 if txe_n is low.
- Throughput: 1 byte per cycle sustained while txe_n is low.
- bytes_sent increments by 1 on each ft_acc and wraps modulo 2^COUNT_WIDTH.
- Flush FSM states: IDLE, ARMED, PULSE.
  - IDLE → ARMED on ft_acc.
  - In ARMED, idle_cnt resets to 0 on any ft_acc or input handshake, or while OUT/SKID is non-empty. Otherwise idle_cnt increments.
  - When idle_cnt reaches FLUSH_TIMEOUT-1 and no input handshake occurs that cycle → PULSE; siwu_n=0 for exactly one cycle, then IDLE.
  - An input handshake on the terminal cycle suppresses the pulse and resets idle_cnt.
  - siwu_n is never low while wr_n is low.
  - FLUSH_TIMEOUT=0: the FSM stays in IDLE; siwu_n is always 1.
- No combinational path from txe_n or s_tvalid to any output.

Decomposition:
- Package ft232h_pkg: typedef ft232h_byte_t (logic[7:0]); enum ft232h_flush_state_t {IDLE, ARMED, PULSE}; localparams for pin idle levels (ACTIVE_LOW_DEASSERT=1). ft232h_bfm also imports ft232h_pkg.
- Sub-module ft232h_tx_skid: the two-entry OUT/SKID buffer with ports clk, reset, s_*, drain, out_valid, out_data. The top holds the flush FSM, counter, and pin mapping.

Test Plan:
1. Assert reset for 3 cycles with s_tvalid=1, s_tdata=0x45 → wr_n=1, siwu_n=1, s_tready=0, bytes_sent=0 throughout; s_tready=1 one edge after release.
2. Stream 0x45..0x4C back-to-back, BFM txe_n low → BFM tdata reads 0x45..0x4C in order; wr_n low for exactly 8 consecutive cycles; bytes_sent=8.
3. Force txe_n high for 5 cycles just after 0x47 is consumed while streaming 0x45..0x4C → data holds 0x48 and wr_n stays 0; s_tready drops once SKID holds 0x49; after release all 8 bytes reach the BFM once each; bytes_sent=8.
4. FLUSH_TIMEOUT=8: send single byte 0x45, then idle → siwu_n=0 for exactly 1 cycle, 8 cycles after wr_n returns high; no further pulses over 100 cycles.
5. FLUSH_TIMEOUT=8: present 0x46 on the terminal idle cycle → no siwu_n pulse that cycle; a pulse occurs 8 idle cycles after 0x46 is consumed.
6. Assert reset with OUT and SKID full (txe_n high) → next edge wr_n=1, bytes_sent=0; after release with txe_n low, the BFM receives no stale bytes.

Source files
------------

// File: rtl/ft232h_pkg.sv
// Shared types and pin levels for the FT232H 245 synchronous FIFO blocks.
// Used by the transmit controller and the ft232h_bfm model.
package ft232h_pkg;

    typedef logic [7:0] ft232h_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        PULSE
    } ft232h_flush_state_t;

    localparam logic ACTIVE_LOW_DEASSERT = 1'b1;

endpackage

// File: rtl/ft232h_tx_skid.sv
// Two-entry OUT/SKID buffer between the byte stream and the FT232H pins.
// s_tready is registered so no input-to-output combinational path exists.
module ft232h_tx_skid
    import ft232h_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       drain,
    output logic       out_valid,
    output logic [7:0] out_data
);

    ft232h_byte_t skid_data;
    logic         skid_valid;
    logic         skid_valid_nxt;
    logic         in_hs;
    logic         load_out;

    assign in_hs    = s_tvalid & s_tready;
    assign load_out = ~out_valid | drain;

    // Next SKID occupancy, needed early to register s_tready
    always_comb begin
        skid_valid_nxt = skid_valid;
        if (load_out) begin
            skid_valid_nxt = 1'b0;
        end else if (in_hs) begin
            skid_valid_nxt = 1'b1;
        end
    end

    // OUT refills from SKID first so byte order is preserved
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            s_tready   <= 1'b0;
        end else begin
            s_tready   <= ~skid_valid_nxt;
            skid_valid <= skid_valid_nxt;
            if (load_out) begin
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= skid_data;
                end else if (in_hs) begin
                    out_valid <= 1'b1;
                    out_data  <= s_tdata;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (in_hs) begin
                skid_data <= s_tdata;
            end
        end
    end

endmodule

// File: rtl/ft232h_sync_fifo_tx.sv
// FT232H 245 synchronous FIFO transmit controller.
// Buffers stream bytes, drives wr_n/data, and pulses siwu_n after idle.
module ft232h_sync_fifo_tx
    import ft232h_pkg::*;
#(
    parameter int FLUSH_TIMEOUT = 64,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic                   txe_n,
    output logic                   wr_n,
    output logic [7:0]             data,
    output logic                   rd_n,
    output logic                   oe_n,
    output logic                   siwu_n,
    output logic [COUNT_WIDTH-1:0] bytes_sent
);

    localparam int IW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam logic [IW-1:0] LAST =
        IW'((FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0);

    logic                out_valid;
    logic [7:0]          out_data;
    logic                ft_acc;
    logic                in_hs;
    logic                busy;
    ft232h_flush_state_t state;
    logic [IW-1:0]       idle_cnt;

    assign ft_acc = out_valid & ~txe_n;
    assign in_hs  = s_tvalid & s_tready;
    // ~s_tready mirrors a full SKID once out of reset
    assign busy   = ft_acc | in_hs | out_valid | ~s_tready;

    assign wr_n = ~out_valid;
    assign data = out_data;
    assign rd_n = ACTIVE_LOW_DEASSERT;
    assign oe_n = ACTIVE_LOW_DEASSERT;

    ft232h_tx_skid u_skid (
        .clk       (clk),
        .reset     (reset),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .drain     (ft_acc),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    // Count bytes actually taken by the FT232H
    always_ff @(posedge clk) begin
        if (reset) begin
            bytes_sent <= '0;
        end else if (ft_acc) begin
            bytes_sent <= bytes_sent + COUNT_WIDTH'(1);
        end
    end

    // Flush FSM: one siwu_n pulse after FLUSH_TIMEOUT idle cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idle_cnt <= '0;
            siwu_n   <= ACTIVE_LOW_DEASSERT;
        end else begin
            siwu_n <= ACTIVE_LOW_DEASSERT;
            case (state)
                IDLE: begin
                    if (ft_acc && (FLUSH_TIMEOUT != 0)) begin
                        state    <= ARMED;
                        idle_cnt <= '0;
                    end
                end
                ARMED: begin
                    if (busy) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == LAST) begin
                        state    <= PULSE;
                        idle_cnt <= '0;
                        siwu_n   <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                PULSE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ft232h_sync_fifo_tx.sv
// Scoreboard bench for ft232h_sync_fifo_tx.
// Directed scenarios followed by randomized traffic.
module tb_ft232h_sync_fifo_tx;

    localparam int FT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_tvalid = 1'b0;
    logic [7:0]  s_tdata = 8'h00;
    logic        txe_n = 1'b0;

    logic        s_tready, wr_n, rd_n, oe_n, siwu_n;
    logic [7:0]  data;
    logic [15:0] bytes_sent;
    logic        s_tready0, wr_n0, rd_n0, oe_n0, siwu_n0;
    logic [7:0]  data0;
    logic [15:0] bytes_sent0;

    ft232h_sync_fifo_tx #(.FLUSH_TIMEOUT(FT), .COUNT_WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .txe_n      (txe_n),
        .wr_n       (wr_n),
        .data       (data),
        .rd_n       (rd_n),
        .oe_n       (oe_n),
        .siwu_n     (siwu_n),
        .bytes_sent (bytes_sent)
    );

    ft232h_sync_fifo_tx #(.FLUSH_TIMEOUT(0), .COUNT_WIDTH(16)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready0),
        .txe_n      (txe_n),
        .wr_n       (wr_n0),
        .data       (data0),
        .rd_n       (rd_n0),
        .oe_n       (oe_n0),
        .siwu_n     (siwu_n0),
        .bytes_sent (bytes_sent0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0]  q[$];
    logic [15:0] exp_cnt = 16'h0;
    logic        exp_siwu = 1'b1;
    logic        armed = 1'b0;
    int          run = 0;
    logic        rst_seen = 1'b0;
    logic        prev_wr = 1'b1;
    int cyc = 0, rise_cyc = 0, pulse_cyc = 0, pulse_cnt = 0;
    int low_cnt = 0, cur_run = 0, max_run = 0, rx_cnt = 0;

    // Monitor: check outputs after each edge, predict the next edge
    always @(negedge clk) begin
        logic       acc, hs, busy;
        logic [7:0] e;
        cyc++;
        if (rst_seen) begin
            chk("rst_wr_n", wr_n, 1);
            chk("rst_siwu_n", siwu_n, 1);
            chk("rst_tready", s_tready, 0);
            chk("rst_tready0", s_tready0, 0);
            chk("rst_bytes", bytes_sent, 0);
        end
        chk("siwu_n", siwu_n, exp_siwu);
        chk("siwu_n0", siwu_n0, 1);
        chk("bytes_sent", bytes_sent, exp_cnt);
        chk("bytes_sent0", bytes_sent0, exp_cnt);
        chk("rd_oe_high", {rd_n, oe_n, rd_n0, oe_n0}, 4'hf);
        chk("siwu_wr_overlap", !wr_n && !siwu_n, 0);
        if (wr_n === 1'b1 && prev_wr === 1'b0) rise_cyc = cyc;
        prev_wr = wr_n;
        if (siwu_n === 1'b0) begin
            pulse_cnt++;
            pulse_cyc = cyc;
        end
        if (wr_n === 1'b0) begin
            low_cnt++;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
        end else begin
            cur_run = 0;
        end
        if (reset) begin
            q.delete();
            exp_cnt  = 16'h0;
            exp_siwu = 1'b1;
            armed    = 1'b0;
            run      = 0;
        end else begin
            acc  = (wr_n === 1'b0) && (txe_n == 1'b0);
            hs   = s_tvalid && (s_tready === 1'b1);
            busy = (q.size() != 0) || hs || acc;
            if (acc) begin
                chk("byte_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("data", data, e);
                    chk("data0", data0, e);
                    rx_cnt++;
                end
                exp_cnt++;
            end
            if (hs) q.push_back(s_tdata);
            if (!exp_siwu) begin
                exp_siwu = 1'b1;
                armed    = 1'b0;
            end else if (armed) begin
                run = busy ? 0 : run + 1;
                if (run == FT) begin
                    exp_siwu = 1'b0;
                    armed    = 1'b0;
                end
            end else if (acc) begin
                armed = 1'b1;
                run   = 0;
            end
        end
        rst_seen = reset;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        s_tvalid = 1'b0;
        tick(n);
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int g;
        s_tvalid = 1'b1;
        s_tdata  = b;
        g = 0;
        @(negedge clk);
        while (s_tready !== 1'b1 && g < 60) begin
            @(negedge clk);
            g++;
        end
        chk("send_timeout", g < 60, 1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a byte already offered
        reset = 1'b1;
        s_tvalid = 1'b1;
        s_tdata = 8'h45;
        tick(3);
        chk("t1_tready_in_reset", s_tready, 0);
        reset = 1'b0;
        tick(1);
        chk("t1_tready_rise", s_tready, 1);

        // Back-to-back stream
        low_cnt = 0;
        max_run = 0;
        rx_cnt = 0;
        for (int i = 0; i < 8; i++) send(8'(8'h45 + i));
        tick(20);
        chk("t2_low_cycles", low_cnt, 8);
        chk("t2_low_run", max_run, 8);
        chk("t2_bytes", bytes_sent, 8);
        chk("t2_rx", rx_cnt, 8);

        // Backpressure after 0x47
        do_reset(2);
        rx_cnt = 0;
        fork
            for (int i = 0; i < 8; i++) send(8'(8'h45 + i));
            begin
                bit found;
                found = 1'b0;
                for (int j = 0; j < 100 && !found; j++) begin
                    @(negedge clk);
                    found = (wr_n === 1'b0) && !txe_n && (data == 8'h47);
                end
                chk("t3_saw_47", found, 1);
                @(posedge clk);
                #1;
                txe_n = 1'b1;
                tick(5);
                chk("t3_hold_data", data, 8'h48);
                chk("t3_hold_wr", wr_n, 0);
                chk("t3_tready_low", s_tready, 0);
                txe_n = 1'b0;
            end
        join
        tick(30);
        chk("t3_bytes", bytes_sent, 8);
        chk("t3_rx", rx_cnt, 8);

        // Single byte then idle: one flush pulse
        do_reset(2);
        pulse_cnt = 0;
        send(8'h45);
        tick(110);
        chk("t4_pulses", pulse_cnt, 1);
        chk("t4_gap", pulse_cyc - rise_cyc, 8);

        // Byte on the terminal idle cycle delays the pulse
        do_reset(2);
        pulse_cnt = 0;
        send(8'h45);
        tick(8);
        s_tvalid = 1'b1;
        s_tdata = 8'h46;
        chk("t5_tready", s_tready, 1);
        tick(1);
        s_tvalid = 1'b0;
        tick(40);
        chk("t5_pulses", pulse_cnt, 1);
        chk("t5_gap", pulse_cyc - rise_cyc, 8);

        // Reset with both buffers full
        do_reset(2);
        txe_n = 1'b1;
        send(8'h45);
        send(8'h46);
        s_tvalid = 1'b1;
        s_tdata = 8'h47;
        tick(3);
        chk("t6_tready_full", s_tready, 0);
        chk("t6_wr_low", wr_n, 0);
        reset = 1'b1;
        s_tvalid = 1'b0;
        tick(1);
        chk("t6_wr_after_rst", wr_n, 1);
        chk("t6_bytes_after_rst", bytes_sent, 0);
        tick(1);
        reset = 1'b0;
        txe_n = 1'b0;
        rx_cnt = 0;
        low_cnt = 0;
        tick(20);
        chk("t6_no_stale_rx", rx_cnt, 0);
        chk("t6_no_stale_wr", low_cnt, 0);
        send(8'h50);
        tick(5);
        chk("t6_rx_new", rx_cnt, 1);

        // Randomized traffic with busy and sparse phases
        do_reset(2);
        for (int i = 0; i < 800; i++) begin
            bit took;
            @(negedge clk);
            took = s_tvalid && (s_tready === 1'b1);
            @(posedge clk);
            #1;
            if (!s_tvalid || took) begin
                if (i % 200 < 100)
                    s_tvalid = ($urandom_range(3) != 0);
                else
                    s_tvalid = ($urandom_range(15) == 0);
                s_tdata = 8'($urandom);
            end
            txe_n = ($urandom_range(3) == 0);
        end
        s_tvalid = 1'b0;
        txe_n = 1'b0;
        tick(40);
        chk("rand_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
